iosys_mem_arbiter: RTL

Shares the single 32-bit IOSys memory port (SDRAM/BSRAM, 8 MB space) between three requesters: the boot firmware loader, the PicoRV32 core and a savestate/DMA engine. It sits between those masters and the memory controller port (valid/ready/addr/wdata/wstrb/rdata). It replaces the ad-hoc loader/CPU mux with registered grant selection, fair arbitration and a per-access timeout.

---
 rtl/iosys_mem_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/iosys_mem_arbiter.sv
// Three-master arbiter for the shared 32-bit IOSys memory port.
// Port 0 (loader) has absolute priority, ports 1/2 round-robin, and each access has a timeout.
module iosys_mem_arbiter #(
   parameter int          TIMEOUT  = 4095,
   parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        boot_lock,
   input  logic        p0_valid,
   input  logic [22:0] p0_addr,
   input  logic [31:0] p0_wdata,
   input  logic [3:0]  p0_wstrb,
   input  logic        p1_valid,
   input  logic [22:0] p1_addr,
   input  logic [31:0] p1_wdata,
   input  logic [3:0]  p1_wstrb,
   input  logic        p2_valid,
   input  logic [22:0] p2_addr,
   input  logic [31:0] p2_wdata,
   input  logic [3:0]  p2_wstrb,
   output logic        p0_ready,
   output logic        p1_ready,
   output logic        p2_ready,
   output logic [31:0] p_rdata,
   output logic        m_valid,
   output logic [22:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb,
   input  logic        m_ready,
   input  logic [31:0] m_rdata,
   output logic        timeout_err,
   output logic [1:0]  grant
);
   localparam int CW = ($clog2(TIMEOUT + 1) > 12) ? $clog2(TIMEOUT + 1) : 12;
   localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

   typedef struct packed {
      logic [22:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } req_t;

   typedef enum logic [1:0] {IDLE, ARB, BUSY} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            rr_p2;
   logic [2:0]      served;
   req_t [2:0]      req;
   logic [2:0]      vld, elig_raw, elig, own;
   logic [1:0]      win;
   logic            busy, tmo, done;

   assign req[0]   = {p0_addr, p0_wdata, p0_wstrb};
   assign req[1]   = {p1_addr, p1_wdata, p1_wstrb};
   assign req[2]   = {p2_addr, p2_wdata, p2_wstrb};
   assign vld      = {p2_valid, p1_valid, p0_valid};
   assign elig_raw = boot_lock ? {2'b00, vld[0]} : vld;
   // served masks the owner for one cycle: its valid is still high after ready
   assign elig     = elig_raw & ~served;

   // rr_p2 set means port 2 was the last of the pair served, so port 1 wins a tie
   always_comb begin
      win = 2'd2;
      if (elig[0])
         win = 2'd0;
      else if (elig[1] && (!elig[2] || rr_p2))
         win = 2'd1;
   end

   always_comb begin
      own = 3'b000;
      case (grant)
         2'd0:    own = 3'b001;
         2'd1:    own = 3'b010;
         2'd2:    own = 3'b100;
         default: own = 3'b000;
      endcase
   end

   assign busy        = (state == BUSY);
   assign tmo         = busy && !m_ready && (TIMEOUT != 0) && (cnt == TMO);
   assign done        = (busy && m_ready) || tmo;
   assign p0_ready    = done && own[0];
   assign p1_ready    = done && own[1];
   assign p2_ready    = done && own[2];
   assign p_rdata     = !done ? 32'h0 : (m_ready ? m_rdata : ERR_DATA);
   assign timeout_err = tmo;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state   <= IDLE;
         m_valid <= 1'b0;
         m_addr  <= '0;
         m_wdata <= '0;
         m_wstrb <= '0;
         grant   <= 2'd3;
         cnt     <= '0;
         rr_p2   <= 1'b1;
         served  <= '0;
      end else begin
         served <= '0;
         case (state)
            IDLE: if (|elig) state <= ARB;
            ARB: begin
               if (|elig) begin
                  state                     <= BUSY;
                  grant                     <= win;
                  m_valid                   <= 1'b1;
                  {m_addr, m_wdata, m_wstrb} <= req[win];
                  cnt                       <= '0;
                  if (win != 2'd0) rr_p2 <= (win == 2'd2);
               end else begin
                  state <= IDLE;
               end
            end
            BUSY: begin
               if (!m_ready) cnt <= cnt + CW'(1);
               if (done) begin
                  m_valid <= 1'b0;
                  grant   <= 2'd3;
                  served  <= own;
                  state   <= (!tmo && |(elig_raw & ~own)) ? ARB : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
